fifo_drain: RTL and testbench

Read-side drain stage that sits directly downstream of the synchronous FIFO. It issues `fifo_rd_en` against the FIFO's `empty` flag and absorbs the FIFO's one-cycle registered read latency. Captured words go into a 3-entry output buffer, which presents them to the consumer on a valid/ready stream. It also keeps a saturating count of delivered beats and a sticky underflow error flag.

---
 rtl/fifo_drain.sv | 91 +++++++++
 tb/tb_fifo_drain.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain.sv
// Read-side drain stage for a synchronous FIFO: hides the FIFO's one-cycle read
// latency behind a 3-entry skid buffer and presents a valid/ready stream.
module fifo_drain #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic                  clr_stats,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic                  err_underflow
);

  localparam int DEPTH = 3;

  logic [DEPTH-1:0][FIFO_WIDTH-1:0] mem_q, mem_d;
  logic [1:0]           count_q, count_d;
  logic [1:0]           wr_ptr_q, wr_ptr_d;
  logic [1:0]           rd_ptr_q, rd_ptr_d;
  logic                 inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0] beat_q, beat_d;
  logic                 err_q, err_d;
  logic                 push, pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    // A read is only issued when a buffer slot is reserved for its return word,
    // so no path from m_ready is needed and a capture can never overflow.
    fifo_rd_en = !rst && !fifo_empty &&
                 (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd3);
    m_valid    = (count_q != 2'd0);
    m_data     = mem_q[rd_ptr_q];
    push       = inflight_q & ~fifo_underflow;
    pop        = m_valid & m_ready;

    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + {1'b0, push} - {1'b0, pop};
    inflight_d = fifo_rd_en;
    beat_d     = beat_q;
    err_d      = err_q;

    if (push) begin
      mem_d[wr_ptr_q] = fifo_data_out;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

    if (pop && (beat_q != {CNT_WIDTH{1'b1}})) beat_d = beat_q + 1'b1;
    if (inflight_q && fifo_underflow) err_d = 1'b1;
    if (clr_stats) begin
      beat_d = '0;
      err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q      <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      beat_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      beat_q     <= beat_d;
      err_q      <= err_d;
    end
  end

  assign beat_count    = beat_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain: a queue-based FIFO and a queue-based output buffer model
// predict every output each cycle, under directed and random traffic.
module tb_fifo_drain;
  localparam int FW   = 16;
  localparam int CW   = 4;
  localparam int MAXB = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] fifo_data_out;
  logic          fifo_empty;
  logic          fifo_underflow;
  logic          fifo_rd_en;
  logic [FW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          clr_stats;
  logic [CW-1:0] beat_count;
  logic          err_underflow;

  fifo_drain #(.FIFO_WIDTH(FW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
    .fifo_underflow(fifo_underflow), .fifo_rd_en(fifo_rd_en),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .clr_stats(clr_stats), .beat_count(beat_count),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Upstream FIFO contents and the buffer as an ordered list of held words.
  logic [FW-1:0] fifo_q[$];
  logic [FW-1:0] ref_buf[$];
  bit            ref_infl = 0;
  int            ref_beat = 0;
  bit            ref_err  = 0;
  bit            ref_m0   = 0;
  logic [FW-1:0] dout_nxt = '0;
  bit            uf_nxt   = 0;
  bit            force_uf = 0;
  int            rd_pulses = 0;

  // One clock cycle: drive FIFO-side inputs, check outputs, advance the model.
  task automatic step();
    bit exp_rd, exp_v, pop;
    fifo_empty     = (fifo_q.size() == 0);
    fifo_data_out  = dout_nxt;
    fifo_underflow = uf_nxt;
    #1;
    exp_rd = !rst && (fifo_q.size() != 0) && (ref_buf.size() + int'(ref_infl) < 3);
    exp_v  = (ref_buf.size() != 0);
    chk("rd_en", fifo_rd_en, exp_rd);
    chk("m_valid", m_valid, exp_v);
    if (exp_v) chk("m_data", m_data, ref_buf[0]);
    else if (ref_m0) chk("m_data_rst", m_data, 0);
    chk("beat_count", beat_count, ref_beat);
    chk("err_underflow", err_underflow, ref_err);
    if (exp_rd) rd_pulses++;

    dout_nxt = FW'($urandom);
    uf_nxt   = 0;
    if (rst) begin
      ref_buf.delete();
      ref_infl = 0;
      ref_beat = 0;
      ref_err  = 0;
      ref_m0   = 1;
    end else begin
      pop = exp_v && m_ready;
      if (pop) begin
        void'(ref_buf.pop_front());
        if (ref_beat < MAXB) ref_beat++;
      end
      if (ref_infl) begin
        if (fifo_underflow) ref_err = 1;
        else begin
          ref_buf.push_back(fifo_data_out);
          ref_m0 = 0;
        end
      end
      if (clr_stats) begin
        ref_beat = 0;
        ref_err  = 0;
      end
      ref_infl = exp_rd;
      if (exp_rd) begin
        dout_nxt = fifo_q.pop_front();
        if (force_uf) begin
          uf_nxt   = 1;
          force_uf = 0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; m_ready = 0; clr_stats = 0;
    fifo_data_out = '0; fifo_empty = 1; fifo_underflow = 0;
    @(negedge clk);

    // Reset with a loaded FIFO: nothing may be read or presented.
    for (int i = 1; i <= 5; i++) fifo_q.push_back(FW'(16'h00A0 + i));
    step(); step();
    rst = 0; m_ready = 1;
    repeat (10) step();
    clr_stats = 1; step(); clr_stats = 0;

    // Streaming 1..8 with m_ready held high.
    for (int i = 1; i <= 8; i++) fifo_q.push_back(FW'(i));
    repeat (14) step();
    chk("stream_beats", beat_count, 8);

    // Backpressure: only three reads outstanding, head stable, then release.
    m_ready = 0; clr_stats = 1; step(); clr_stats = 0;
    for (int i = 0; i < 6; i++) fifo_q.push_back(FW'(16'h0B00 + i));
    rd_pulses = 0;
    repeat (8) step();
    chk("bp_rd_pulses", rd_pulses, 3);
    chk("bp_head", m_data, 16'h0B00);
    m_ready = 1;
    repeat (8) step();
    chk("bp_beats", beat_count, 6);

    // Underflow on a capture: word dropped, flag sticky, cleared by clr_stats.
    for (int i = 0; i < 4; i++) fifo_q.push_back(FW'(16'h0C00 + i));
    force_uf = 1;
    repeat (8) step();
    chk("uf_sticky", err_underflow, 1);
    chk("uf_beats", beat_count, 9);
    clr_stats = 1; step(); clr_stats = 0;
    chk("clr_err", err_underflow, 0);
    chk("clr_beat", beat_count, 0);

    // Reset the cycle after a read: the returning word must be discarded.
    for (int i = 0; i < 3; i++) fifo_q.push_back(FW'(16'h0D00 + i));
    step();
    rst = 1; step(); rst = 0;
    chk("rst_mvalid", m_valid, 0);
    repeat (6) step();

    // Saturation at 15, then clear coinciding with a pop.
    clr_stats = 1; step(); clr_stats = 0;
    for (int i = 0; i < 20; i++) fifo_q.push_back(FW'($urandom));
    repeat (26) step();
    chk("sat", beat_count, 15);
    for (int i = 0; i < 3; i++) fifo_q.push_back(FW'(16'h0E00 + i));
    step(); step();
    chk("clr_pop_valid", m_valid, 1);
    clr_stats = 1; step(); clr_stats = 0;
    chk("clr_pop", beat_count, 0);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < 20) fifo_q.push_back(FW'($urandom));
      m_ready   = ($urandom_range(0, 9) < 7);
      clr_stats = ($urandom_range(0, 59) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 29) == 0) force_uf = 1;
      step();
    end
    rst = 0; clr_stats = 0; m_ready = 1; force_uf = 0;
    repeat (30) step();
    chk("drained", m_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
